l2mp_trace_collector: RTL

- Upstream feeder of the L2 main-pipe trace writer.
- Samples main-pipe stage-3 task metadata every cycle and filters it by channel.
- Stamps each record with a free-running cycle counter, buffers it in a small FIFO, and drains one record per cycle as the writer's en/data_*/stamp stream.
- While the writer is paused (out_stall), records are held; overflow drops are counted.

---
 rtl/l2mp_trace_pkg.sv | 40 ++++
 rtl/l2mp_trace_fifo.sv | 54 +++++
 rtl/l2mp_trace_collector.sv | 122 ++++++++++++
 3 files changed

// File: rtl/l2mp_trace_pkg.sv
// Shared types and constants for the L2 main-pipe trace collector.
// Record layout is common to the filter, the FIFO and the output mapping.
package l2mp_trace_pkg;

    localparam int SSET_W      = 9;
    localparam int TAG_W       = 19;
    localparam int ID_W        = 8;
    localparam int WAY_W       = 3;
    localparam int OPC_W       = 3;
    localparam int CH_W        = 3;
    localparam int STAMP_MAX_W = 64;

    localparam logic [CH_W-1:0] CH_A = 3'b001;
    localparam logic [CH_W-1:0] CH_B = 3'b010;
    localparam logic [CH_W-1:0] CH_C = 3'b100;

    typedef struct packed {
        logic [WAY_W-1:0]       metaWway;
        logic                   metaWvalid;
        logic [ID_W-1:0]        mshrId;
        logic [ID_W-1:0]        allocPtr;
        logic                   allocValid;
        logic [WAY_W-1:0]       dirWay;
        logic                   dirHit;
        logic [SSET_W-1:0]      sset;
        logic [TAG_W-1:0]       tag;
        logic [OPC_W-1:0]       opcode;
        logic [CH_W-1:0]        channel;
        logic                   mshrTask;
        logic [STAMP_MAX_W-1:0] stamp;
    } l2mp_rec_t;

    function automatic logic chanHit(
        input logic [CH_W-1:0] ch,
        input logic [CH_W-1:0] mask
    );
        return |(ch & mask);
    endfunction

endpackage

// File: rtl/l2mp_trace_fifo.sv
// Record FIFO with wrap-bit pointers; a full FIFO still takes a push
// when the head is popped in the same cycle.
module l2mp_trace_fifo
    import l2mp_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  l2mp_rec_t   wrData,
    input  logic        pop,
    output l2mp_rec_t   rdData,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    logic        doPush;
    logic        doPop;
    l2mp_rec_t   mem [DEPTH];

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) &&
                    (wrPtr[AW] != rdPtr[AW]);
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign level  = wrPtr - rdPtr;
    assign rdData = mem[rdPtr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage is cleared so the head reads as zero after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (doPush) begin
            mem[wrPtr[AW-1:0]] <= wrData;
        end
    end

endmodule

// File: rtl/l2mp_trace_collector.sv
// Filters stage-3 task metadata by channel, stamps and buffers it,
// and drains one record per cycle to the trace writer.
module l2mp_trace_collector
    import l2mp_trace_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 64,
    parameter int CNT_W   = 32,
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_enable,
    input  logic [CH_W-1:0]    cfg_channel_mask,
    input  logic               out_stall,
    input  logic               in_valid,
    input  logic [WAY_W-1:0]   in_metaWway,
    input  logic               in_metaWvalid,
    input  logic [ID_W-1:0]    in_mshrId,
    input  logic [ID_W-1:0]    in_allocPtr,
    input  logic               in_allocValid,
    input  logic [WAY_W-1:0]   in_dirWay,
    input  logic               in_dirHit,
    input  logic [SSET_W-1:0]  in_sset,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [OPC_W-1:0]   in_opcode,
    input  logic [CH_W-1:0]    in_channel,
    input  logic               in_mshrTask,
    output logic               out_en,
    output logic [WAY_W-1:0]   out_data_metaWway,
    output logic               out_data_metaWvalid,
    output logic [ID_W-1:0]    out_data_mshrId,
    output logic [ID_W-1:0]    out_data_allocPtr,
    output logic               out_data_allocValid,
    output logic [WAY_W-1:0]   out_data_dirWay,
    output logic               out_data_dirHit,
    output logic [SSET_W-1:0]  out_data_sset,
    output logic [TAG_W-1:0]   out_data_tag,
    output logic [OPC_W-1:0]   out_data_opcode,
    output logic [CH_W-1:0]    out_data_channel,
    output logic               out_data_mshrTask,
    output logic [STAMP_W-1:0] out_stamp,
    output logic [CNT_W-1:0]   drop_count,
    output logic               overflow,
    output logic [LW-1:0]      fifo_level
);

    logic [STAMP_W-1:0] stampCnt;
    logic               accept;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               drop;
    l2mp_rec_t          inRec;
    l2mp_rec_t          headRec;

    assign accept = in_valid & cfg_enable &
                    chanHit(in_channel, cfg_channel_mask);
    assign out_en = ~fifoEmpty & ~out_stall;
    assign drop   = accept & fifoFull & ~out_en;

    // Bundle the sampled stage-3 fields with the current stamp.
    always_comb begin
        inRec            = '0;
        inRec.metaWway   = in_metaWway;
        inRec.metaWvalid = in_metaWvalid;
        inRec.mshrId     = in_mshrId;
        inRec.allocPtr   = in_allocPtr;
        inRec.allocValid = in_allocValid;
        inRec.dirWay     = in_dirWay;
        inRec.dirHit     = in_dirHit;
        inRec.sset       = in_sset;
        inRec.tag        = in_tag;
        inRec.opcode     = in_opcode;
        inRec.channel    = in_channel;
        inRec.mshrTask   = in_mshrTask;
        inRec.stamp      = STAMP_MAX_W'(stampCnt);
    end

    l2mp_trace_fifo #(.DEPTH(DEPTH)) uFifo (
        .clock  (clock),
        .reset  (reset),
        .push   (accept),
        .wrData (inRec),
        .pop    (out_en),
        .rdData (headRec),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .level  (fifo_level)
    );

    // Free-running capture timestamp, wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stampCnt <= '0;
        else       stampCnt <= stampCnt + 1'b1;
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    assign out_data_metaWway   = headRec.metaWway;
    assign out_data_metaWvalid = headRec.metaWvalid;
    assign out_data_mshrId     = headRec.mshrId;
    assign out_data_allocPtr   = headRec.allocPtr;
    assign out_data_allocValid = headRec.allocValid;
    assign out_data_dirWay     = headRec.dirWay;
    assign out_data_dirHit     = headRec.dirHit;
    assign out_data_sset       = headRec.sset;
    assign out_data_tag        = headRec.tag;
    assign out_data_opcode     = headRec.opcode;
    assign out_data_channel    = headRec.channel;
    assign out_data_mshrTask   = headRec.mshrTask;
    assign out_stamp           = headRec.stamp[STAMP_W-1:0];

endmodule
